ahb_lite_fir_subordinate: RTL and testbench
===========================================

# ahb_lite_fir_subordinate

AHB-Lite subordinate that exposes the FIR filter's control and data registers on a 16-bit bus. It sits between the bus manager and the FIR datapath/controller. It accepts new samples and four coefficients, and flags loads of new coefficient sets. It reports status and results, and returns an error response on illegal accesses.

## Interface
- No parameters.
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- hsel  in  1  subordinate select.
- haddr  in  4  byte address.
- hsize  in  1  transfer size: 0 = byte, 1 = halfword.
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write.
- hwdata  in  16  write data, valid in the data phase.
- hrdata  out  16  read data, valid in the data phase.
- hresp  out  1  error response.
- modwait  in  1  FIR busy.
- fir_out  in  16  FIR result.
- err  in  1  FIR error flag.
- clear_coeff  in  1  FIR has consumed the coefficient set.
- coefficient_num  in  2  selects the coefficient driven on fir_coefficient.
- sample_data  out  16  sample register.
- data_ready  out  1  new sample pending.
- new_coefficient_set  out  1  coefficient load request.
- fir_coefficient  out  16  equals F[coefficient_num], combinational.

## Operation
- **Transfer qualification:** a transfer is active when hsel=1 and htrans is NONSEQ or SEQ. IDLE/BUSY and hsel=0 cause no access and no error.
- **Address phase:** on an active transfer, haddr, hsize and hwrite are registered into data-phase registers.
- **Register map (little-endian, halfword at even address):**
  - 0x0–0x1 status, read-only: bit0 = modwait | new_coefficient_set; bit8 = err; all other bits 0.
  - 0x2–0x3 result, read-only: fir_out.
  - 0x4–0x5 sample, read/write; drives sample_data.
  - 0x6, 0x8, 0xA, 0xC: F0, F1, F2, F3, read/write.
  - 0xE new-coefficient register, read/write. Only bit0 is stored and drives new_coefficient_set; 0xF reads 0.
- **Byte access (hsize=0):**
  - Even address writes hwdata[7:0] into the low byte; odd address writes hwdata[15:8] into the high byte.
  - Reads always return the full halfword.
- **Halfword access** ignores haddr[0].
- **Errors:** a write to 0x0–0x3 asserts hresp in that transfer's data phase and changes no register. Reads never error.
- **data_ready:** set by a write to the sample register; cleared when modwait=1. A new sample write wins over clearing in the same cycle.
- **new_coefficient_set:** clear_coeff=1 clears bit0 of 0xE. A bus write of 1 to 0xE in the same cycle wins over the clear.
- **Read-after-write hazard:** if an active read's address phase targets the same halfword as the write currently in its data phase, hrdata returns the forwarded hwdata (byte-merged), not the stale register.
- hrdata is 0 when no read is in its data phase.

## Timing
- Zero wait states; no hready.
- Address phase in cycle N; data phase in cycle N+1.
- Write data is sampled at the end of N+1; the register is visible from cycle N+2.
- A read's hrdata is valid combinationally during N+1.
- hresp is high for exactly the one data-phase cycle of the erroneous write.
- **Reset values:** all registers, data_ready, new_coefficient_set, hresp and the data-phase registers are 0.
- Outputs at reset: sample_data=0, fir_coefficient=0, hrdata=0.
- Reset mid-transfer aborts it; no write commits.
- Back-to-back transfers are fully pipelined.

## Structure
- Shared package holds:
  - address constants ADDR_STATUS=0x0, ADDR_RESULT=0x2, ADDR_SAMPLE=0x4, ADDR_F0..F3=0x6/0x8/0xA/0xC, ADDR_NEWCOEF=0xE;
  - htrans encodings as an enum.
- Single flat module, no sub-modules. The coefficient array is an internal 4×16 register.

## Test plan
- Reset, fir_out=0xABCD, halfword read at 0x2 → hrdata=0xABCD, hresp=0.
- Halfword write 0x0001 to 0x0 → hresp=1 for one cycle, no state change.
- With modwait=1 then err=1, read 0x0 → 0x0001, then 0x0101.
- Write 0x0001 to 0x4 → sample_data=0x0001 and data_ready=1 until modwait=1; readback at 0x4 = 0x0001.
- Write 0x0001 to each of 0x6/0x8/0xA/0xC and read back 0x0001. Sweep coefficient_num 0–3 → fir_coefficient follows.
- Write 0xFFFF to 0xA immediately followed by a read of 0xA → read returns 0xFFFF (forwarded).
- Write 1 to 0xE → new_coefficient_set=1; pulse clear_coeff → 0.
- Byte write 0x12 to 0x5 → high byte only updated.

Source files
------------

// File: rtl/ahb_lite_fir_subordinate_pkg.sv
// Shared definitions for the FIR AHB-Lite subordinate: register map,
// transfer-type encodings and the byte-lane merge helper.
package ahb_lite_fir_subordinate_pkg;

    // Byte addresses of the halfword registers
    localparam logic [3:0] ADDR_STATUS  = 4'h0;
    localparam logic [3:0] ADDR_RESULT  = 4'h2;
    localparam logic [3:0] ADDR_SAMPLE  = 4'h4;
    localparam logic [3:0] ADDR_F0      = 4'h6;
    localparam logic [3:0] ADDR_F1      = 4'h8;
    localparam logic [3:0] ADDR_F2      = 4'hA;
    localparam logic [3:0] ADDR_F3      = 4'hC;
    localparam logic [3:0] ADDR_NEWCOEF = 4'hE;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Replace the enabled byte lanes of old_val with the matching lanes of wdata
    function automatic logic [15:0] byte_merge(input logic [15:0] old_val,
                                               input logic [15:0] wdata,
                                               input logic        lane_lo,
                                               input logic        lane_hi);
        byte_merge = {lane_hi ? wdata[15:8] : old_val[15:8],
                      lane_lo ? wdata[7:0]  : old_val[7:0]};
    endfunction

endpackage

// File: rtl/ahb_lite_fir_subordinate.sv
// AHB-Lite subordinate exposing the FIR sample, coefficient, status and
// result registers. Zero wait states; address phase is registered and the
// write data is committed at the end of the data phase.
module ahb_lite_fir_subordinate
    import ahb_lite_fir_subordinate_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [3:0]  haddr,
    input  logic        hsize,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [15:0] hwdata,
    output logic [15:0] hrdata,
    output logic        hresp,
    input  logic        modwait,
    input  logic [15:0] fir_out,
    input  logic        err,
    input  logic        clear_coeff,
    input  logic [1:0]  coefficient_num,
    output logic [15:0] sample_data,
    output logic        data_ready,
    output logic        new_coefficient_set,
    output logic [15:0] fir_coefficient
);

    logic              active;
    logic              dp_valid_reg, dp_write_reg, dp_size_reg;
    logic [3:0]        dp_addr_reg;
    logic [2:0]        dp_hw;
    logic              hresp_reg;
    logic              wr_en, lane_lo, lane_hi, is_coef;
    logic [1:0]        coef_sel;
    logic [15:0]       sample_reg, sample_next;
    logic [3:0][15:0]  coeff_reg, coeff_next;
    logic              newcoef_reg, newcoef_next;
    logic              data_ready_reg, data_ready_next;
    logic              fwd_valid_reg;
    logic [15:0]       fwd_data_reg, fwd_next;

    assign active   = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign dp_hw    = dp_addr_reg[3:1];
    // Writes to status/result are rejected: they raise hresp and commit nothing
    assign wr_en    = dp_valid_reg && dp_write_reg && (dp_addr_reg[3:2] != 2'b00);
    assign lane_lo  = dp_size_reg || !dp_addr_reg[0];
    assign lane_hi  = dp_size_reg ||  dp_addr_reg[0];
    assign is_coef  = (dp_hw >= ADDR_F0[3:1]) && (dp_hw <= ADDR_F3[3:1]);
    assign coef_sel = 2'(dp_hw - ADDR_F0[3:1]);

    // Next-state of the sample, data_ready and new-coefficient bit
    always_comb begin
        sample_next     = sample_reg;
        data_ready_next = data_ready_reg;
        newcoef_next    = newcoef_reg;
        if (modwait)
            data_ready_next = 1'b0;
        if (wr_en && dp_hw == ADDR_SAMPLE[3:1]) begin
            sample_next     = byte_merge(sample_reg, hwdata, lane_lo, lane_hi);
            data_ready_next = 1'b1;
        end
        if (clear_coeff)
            newcoef_next = 1'b0;
        // Only bit0 of the low byte is stored; a bus write beats clear_coeff
        if (wr_en && dp_hw == ADDR_NEWCOEF[3:1] && lane_lo)
            newcoef_next = hwdata[0];
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_coeff
            assign coeff_next[gi] = (wr_en && is_coef && coef_sel == 2'(gi))
                                  ? byte_merge(coeff_reg[gi], hwdata, lane_lo, lane_hi)
                                  : coeff_reg[gi];
            // Coefficient register gi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) coeff_reg[gi] <= '0;
                else     coeff_reg[gi] <= coeff_next[gi];
            end
        end
    endgenerate

    // Value a read of the halfword being written would see next cycle
    always_comb begin
        fwd_next = '0;
        if (dp_hw == ADDR_SAMPLE[3:1])
            fwd_next = sample_next;
        else if (is_coef)
            fwd_next = coeff_next[coef_sel];
        else if (dp_hw == ADDR_NEWCOEF[3:1])
            fwd_next = {15'b0, newcoef_next};
    end

    // Address-phase capture, error flag and read-after-write forwarding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid_reg  <= 1'b0;
            dp_write_reg  <= 1'b0;
            dp_size_reg   <= 1'b0;
            dp_addr_reg   <= '0;
            hresp_reg     <= 1'b0;
            fwd_valid_reg <= 1'b0;
            fwd_data_reg  <= '0;
        end else begin
            dp_valid_reg  <= active;
            if (active) begin
                dp_write_reg <= hwrite;
                dp_size_reg  <= hsize;
                dp_addr_reg  <= haddr;
            end
            hresp_reg     <= active && hwrite && (haddr[3:2] == 2'b00);
            fwd_valid_reg <= active && !hwrite && wr_en && (haddr[3:1] == dp_hw);
            fwd_data_reg  <= fwd_next;
        end
    end

    // Datapath-facing registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_reg     <= '0;
            data_ready_reg <= 1'b0;
            newcoef_reg    <= 1'b0;
        end else begin
            sample_reg     <= sample_next;
            data_ready_reg <= data_ready_next;
            newcoef_reg    <= newcoef_next;
        end
    end

    // Read data for the read currently in its data phase, else zero
    always_comb begin
        hrdata = '0;
        if (dp_valid_reg && !dp_write_reg) begin
            if (fwd_valid_reg)
                hrdata = fwd_data_reg;
            else if (dp_hw == ADDR_STATUS[3:1])
                hrdata = {7'b0, err, 7'b0, modwait | newcoef_reg};
            else if (dp_hw == ADDR_RESULT[3:1])
                hrdata = fir_out;
            else if (dp_hw == ADDR_SAMPLE[3:1])
                hrdata = sample_reg;
            else if (is_coef)
                hrdata = coeff_reg[coef_sel];
            else
                hrdata = {15'b0, newcoef_reg};
        end
    end

    assign hresp               = hresp_reg;
    assign sample_data         = sample_reg;
    assign data_ready          = data_ready_reg;
    assign new_coefficient_set = newcoef_reg;
    assign fir_coefficient     = coeff_reg[coefficient_num];

endmodule

// File: tb/tb_ahb_lite_fir_subordinate.sv
// Directed plus randomized bench for ahb_lite_fir_subordinate with a
// register-level reference model of the FIR register file.
module tb_ahb_lite_fir_subordinate;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel = 1'b0;
    logic [3:0]  haddr = '0;
    logic        hsize = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [15:0] hwdata = '0;
    logic [15:0] hrdata;
    logic        hresp;
    logic        modwait = 1'b0;
    logic [15:0] fir_out = '0;
    logic        err = 1'b0;
    logic        clear_coeff = 1'b0;
    logic [1:0]  coefficient_num = '0;
    logic [15:0] sample_data;
    logic        data_ready;
    logic        new_coefficient_set;
    logic [15:0] fir_coefficient;

    ahb_lite_fir_subordinate dut (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .hsize(hsize),
        .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
        .hresp(hresp), .modwait(modwait), .fir_out(fir_out), .err(err),
        .clear_coeff(clear_coeff), .coefficient_num(coefficient_num),
        .sample_data(sample_data), .data_ready(data_ready),
        .new_coefficient_set(new_coefficient_set),
        .fir_coefficient(fir_coefficient)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [15:0] m_sample;
    logic [15:0] m_coef [4];
    logic        m_dr, m_nc;

    // Transfer whose data phase is the current cycle
    logic        prev_act = 1'b0, prev_wr = 1'b0, prev_sz = 1'b0;
    logic [3:0]  prev_ad = '0;
    logic [15:0] pend_wd = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_sample = '0;
        for (int i = 0; i < 4; i++) m_coef[i] = '0;
        m_dr = 1'b0;
        m_nc = 1'b0;
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] ad);
        case (ad >> 1)
            0:       return {7'b0, err, 7'b0, modwait | m_nc};
            1:       return fir_out;
            2:       return m_sample;
            3, 4, 5, 6: return m_coef[(ad >> 1) - 3];
            default: return {15'b0, m_nc};
        endcase
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old_v, input logic sz,
                                          input logic odd, input logic [15:0] wd);
        if (sz)  return wd;
        if (odd) return (old_v & 16'h00FF) | (wd & 16'hFF00);
        return (old_v & 16'hFF00) | (wd & 16'h00FF);
    endfunction

    // Commit the data-phase transfer into the model at the clock edge
    task automatic model_commit();
        logic wrote_sample;
        logic wrote_nc;
        wrote_sample = 1'b0;
        wrote_nc     = 1'b0;
        if (prev_act && prev_wr && prev_ad >= 4) begin
            case (prev_ad >> 1)
                2: begin
                    m_sample = merge(m_sample, prev_sz, prev_ad[0], pend_wd);
                    wrote_sample = 1'b1;
                end
                3, 4, 5, 6: m_coef[(prev_ad >> 1) - 3] =
                    merge(m_coef[(prev_ad >> 1) - 3], prev_sz, prev_ad[0], pend_wd);
                default: if (prev_sz || !prev_ad[0]) begin
                    m_nc = pend_wd[0];
                    wrote_nc = 1'b1;
                end
            endcase
        end
        if (wrote_sample)  m_dr = 1'b1;
        else if (modwait)  m_dr = 1'b0;
        if (!wrote_nc && clear_coeff) m_nc = 1'b0;
    endtask

    task automatic check_outputs();
        logic [15:0] exp_rd;
        logic        exp_resp;
        exp_rd   = (prev_act && !prev_wr) ? model_read(prev_ad) : 16'h0;
        exp_resp = prev_act && prev_wr && (prev_ad < 4);
        chk($sformatf("hrdata@%h", prev_ad), hrdata, exp_rd);
        chk("hresp", {15'b0, hresp}, {15'b0, exp_resp});
        chk("sample_data", sample_data, m_sample);
        chk("data_ready", {15'b0, data_ready}, {15'b0, m_dr});
        chk("new_coefficient_set", {15'b0, new_coefficient_set}, {15'b0, m_nc});
        chk($sformatf("fir_coefficient[%0d]", coefficient_num), fir_coefficient,
            m_coef[coefficient_num]);
    endtask

    // One bus cycle: new address phase plus data phase of the previous transfer
    task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic sz, input logic [3:0] ad, input logic [15:0] wd);
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = sz;
        haddr  = ad;
        hwdata = pend_wd;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_commit();
        #1;
        prev_act = sel && trans[1];
        prev_wr  = wr;
        prev_sz  = sz;
        prev_ad  = ad;
        pend_wd  = wd;
        $display("cycle t=%0t sel=%0b trans=%0d wr=%0b sz=%0b addr=%h wd=%h",
                 $time, sel, trans, wr, sz, ad, wd);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 16'h0);
    endtask

    initial begin
        model_reset();
        fir_out = 16'hABCD;
        @(posedge clk);
        @(negedge clk);
        chk("reset hrdata", hrdata, 16'h0);
        chk("reset hresp", {15'b0, hresp}, 16'h0);
        chk("reset sample_data", sample_data, 16'h0);
        chk("reset fir_coefficient", fir_coefficient, 16'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Result read
        step(1, 2'b10, 0, 1, 4'h2, 16'h0); idle();
        // Illegal write to status, then make sure nothing changed
        step(1, 2'b10, 1, 1, 4'h0, 16'h0001); idle(); idle();
        // Status with modwait, then with err
        modwait = 1; step(1, 2'b10, 0, 1, 4'h0, 0); idle();
        err = 1;     step(1, 2'b10, 0, 1, 4'h0, 0); idle();
        modwait = 0; err = 0;
        // Sample write, data_ready until modwait, readback
        step(1, 2'b10, 1, 1, 4'h4, 16'h0001); idle(); idle();
        modwait = 1; idle(); modwait = 0;
        step(1, 2'b10, 0, 1, 4'h4, 0); idle();
        // Coefficients write/readback and selector sweep
        for (int k = 0; k < 4; k++) step(1, 2'b10, 1, 1, 4'(6 + 2 * k), 16'h0001);
        for (int k = 0; k < 4; k++) step(1, 2'b11, 0, 1, 4'(6 + 2 * k), 0);
        idle();
        for (int k = 0; k < 4; k++) begin coefficient_num = 2'(k); idle(); end
        // Write immediately followed by read of the same register
        step(1, 2'b10, 1, 1, 4'hA, 16'hFFFF); step(1, 2'b10, 0, 1, 4'hA, 0); idle();
        // New-coefficient flag and clear
        step(1, 2'b10, 1, 1, 4'hE, 16'h0001); idle(); idle();
        clear_coeff = 1; idle(); clear_coeff = 0; idle();
        // Byte write to the high byte of the sample
        step(1, 2'b10, 1, 0, 4'h5, 16'h1200); idle();
        step(1, 2'b10, 0, 0, 4'h4, 0); idle();

        // Randomized pipelined traffic
        for (int n = 0; n < 400; n++) begin
            modwait         = ($urandom_range(0, 3) == 0);
            clear_coeff     = ($urandom_range(0, 5) == 0);
            err             = 1'($urandom);
            fir_out         = 16'($urandom);
            coefficient_num = 2'($urandom);
            step(($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), 16'($urandom));
        end
        modwait = 0; clear_coeff = 0;

        // Reset during a write's data phase must abort the write
        step(1, 2'b10, 1, 1, 4'h4, 16'h5A5A);
        hsel = 0; htrans = 2'b00; hwdata = pend_wd;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        prev_act = 1'b0;
        idle(); idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
